// File: rtl/fifo_burst_writer.sv
// Write-side burst producer for the dual-clock FIFO: emits an optional length header
// followed by cmd_len payload words from a valid/ready stream, honouring fifo_full.
module fifo_burst_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = 8,
    parameter int HEADER_EN   = 1,
    parameter int STALL_LIMIT = 256
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  fifo_full,
    output logic                  fifo_w_en,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           words_sent,
    output logic                  stall_err
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
    logic                  w_en_reg, w_en_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  done_reg, done_next;
    logic [15:0]           words_reg, words_next;
    logic [STALL_W-1:0]    stall_cnt_reg, stall_cnt_next;
    logic                  stall_err_reg, stall_err_next;

    logic                  consume;
    logic                  can_load;
    logic [DATA_WIDTH-1:0] header_word;

    generate
        if (DATA_WIDTH > LEN_WIDTH) begin : g_hdr_pad
            assign header_word = {{(DATA_WIDTH - LEN_WIDTH){1'b0}}, cmd_len};
        end else begin : g_hdr_exact
            assign header_word = cmd_len;
        end
    endgenerate

    // The output register behaves as a one-deep skid stage: it may refill on the
    // same edge it is drained, giving one word per cycle.
    assign consume  = w_en_reg && !fifo_full;
    assign can_load = !w_en_reg || !fifo_full;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        w_en_next      = w_en_reg && !consume;
        data_next      = data_reg;
        done_next      = 1'b0;
        cmd_ready      = 1'b0;
        s_ready        = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    remaining_next = cmd_len;
                    // DRAIN only exits once the register is empty, so IDLE can load the header freely.
                    if (HEADER_EN != 0) begin
                        w_en_next = 1'b1;
                        data_next = header_word;
                    end
                    state_next = (cmd_len != '0) ? DATA : DRAIN;
                end
            end
            DATA: begin
                s_ready = can_load && (remaining_reg != '0);
                if (s_valid && s_ready) begin
                    w_en_next      = 1'b1;
                    data_next      = s_data;
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!w_en_reg || consume) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        words_next     = words_reg + 16'(consume);
        stall_cnt_next = stall_cnt_reg;
        if (consume) begin
            stall_cnt_next = '0;
        end else if (w_en_reg && fifo_full && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
        end
        stall_err_next = stall_err_reg || (stall_cnt_next == STALL_MAX);
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            w_en_reg      <= 1'b0;
            data_reg      <= '0;
            done_reg      <= 1'b0;
            words_reg     <= '0;
            stall_cnt_reg <= '0;
            stall_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            w_en_reg      <= w_en_next;
            data_reg      <= data_next;
            done_reg      <= done_next;
            words_reg     <= words_next;
            stall_cnt_reg <= stall_cnt_next;
            stall_err_reg <= stall_err_next;
        end
    end

    assign fifo_w_en    = w_en_reg;
    assign fifo_data_in = data_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign words_sent   = words_reg;
    assign stall_err    = stall_err_reg;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: per-cycle vector table plus hand-written
// stall and reset sequences; a monitor checks every FIFO write against an expected list.
module tb_fifo_burst_writer;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic        busy;
    logic        done;
    logic [15:0] words_sent;
    logic        stall_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    fifo_burst_writer #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8),
        .HEADER_EN  (1),
        .STALL_LIMIT(256)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_data_in(fifo_data_in),
        .busy        (busy),
        .done        (done),
        .words_sent  (words_sent),
        .stall_err   (stall_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       cv;
        logic [7:0] len;
        logic       sv;
        logic [7:0] sd;
        logic       full;
        logic       e_wen;
        logic [7:0] e_data;
        logic       e_sready;
        logic       e_busy;
        logic       e_done;
        logic [15:0] e_words;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic cv, logic [7:0] len, logic sv, logic [7:0] sd, logic full,
                                logic e_wen, logic [7:0] e_data, logic e_sready, logic e_busy,
                                logic e_done, logic [15:0] e_words);
        vec_t v;
        v.cv = cv; v.len = len; v.sv = sv; v.sd = sd; v.full = full;
        v.e_wen = e_wen; v.e_data = e_data; v.e_sready = e_sready;
        v.e_busy = e_busy; v.e_done = e_done; v.e_words = e_words;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive(input logic cv, input logic [7:0] len, input logic sv,
                         input logic [7:0] sd, input logic full);
        @(negedge w_clk);
        cmd_valid = cv; cmd_len = len; s_valid = sv; s_data = sd; fifo_full = full;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge w_clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Write monitor: samples 1 time unit before each rising edge.
    always begin
        @(negedge w_clk);
        #4;
        if (!w_rst && fifo_w_en && !fifo_full) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_data_in), 32'hFFFF_FFFF);
            end else begin
                chk("fifo_write_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        w_rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;

        // Scenarios 2, 3, 4 as per-cycle vectors (checked 1 unit after each falling edge).
        tbl.push_back(mk(1, 8'd4, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 16'd0));
        tbl.push_back(mk(1, 8'd9, 1, 8'hA1, 0, 1, 8'h04, 1, 1, 0, 16'd0));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA2, 0, 1, 8'hA1, 1, 1, 0, 16'd1));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA3, 0, 1, 8'hA2, 1, 1, 0, 16'd2));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA4, 0, 1, 8'hA3, 1, 1, 0, 16'd3));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 1, 8'hA4, 0, 1, 0, 16'd4));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 16'd5));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 16'd5));
        tbl.push_back(mk(1, 8'd4, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 16'd5));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA1, 0, 1, 8'h04, 1, 1, 0, 16'd5));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA2, 0, 1, 8'hA1, 1, 1, 0, 16'd6));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA3, 1, 1, 8'hA2, 0, 1, 0, 16'd7));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA3, 1, 1, 8'hA2, 0, 1, 0, 16'd7));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA3, 1, 1, 8'hA2, 0, 1, 0, 16'd7));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA3, 0, 1, 8'hA2, 1, 1, 0, 16'd7));
        tbl.push_back(mk(0, 8'd0, 1, 8'hA4, 0, 1, 8'hA3, 1, 1, 0, 16'd8));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 1, 8'hA4, 0, 1, 0, 16'd9));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 16'd10));
        tbl.push_back(mk(1, 8'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 16'd10));
        tbl.push_back(mk(0, 8'd0, 1, 8'hFF, 0, 1, 8'h00, 0, 1, 0, 16'd10));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 16'd11));

        exp_q = '{8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                  8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                  8'h00,
                  8'h02, 8'hB1, 8'hB2,
                  8'h04, 8'hC1,
                  8'h02, 8'hD1, 8'hD2};

        // Scenario 1: reset release, then an asynchronous mid-cycle assertion.
        repeat (2) @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        chk("rst_fifo_w_en", 32'(fifo_w_en), 32'd0);
        chk("rst_fifo_data", 32'(fifo_data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        chk("rst_stall_err", 32'(stall_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge w_clk);
        #2 w_rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge w_clk);
        w_rst = 1'b0;

        // Scenarios 2-4 from the table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cv, tbl[i].len, tbl[i].sv, tbl[i].sd, tbl[i].full);
            #1;
            chk($sformatf("v%0d_fifo_w_en", i), 32'(fifo_w_en), 32'(tbl[i].e_wen));
            if (tbl[i].e_wen)
                chk($sformatf("v%0d_fifo_data_in", i), 32'(fifo_data_in), 32'(tbl[i].e_data));
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_sready));
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(!tbl[i].e_busy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_words_sent", i), 32'(words_sent), 32'(tbl[i].e_words));
        end

        // Scenario 5: header blocked for 256 edges.
        drive(1, 8'd2, 0, 8'h00, 0);
        drive(0, 8'd0, 1, 8'hB1, 1);
        repeat (255) @(posedge w_clk);
        #1;
        chk("stall_255_err", 32'(stall_err), 32'd0);
        chk("stall_255_s_ready", 32'(s_ready), 32'd0);
        chk("stall_255_data", 32'(fifo_data_in), 32'h02);
        @(posedge w_clk);
        #1;
        chk("stall_256_err", 32'(stall_err), 32'd1);
        drive(0, 8'd0, 1, 8'hB1, 0);
        drive(0, 8'd0, 1, 8'hB2, 0);
        drive(0, 8'd0, 0, 8'h00, 0);
        wait_done("stall_burst_done");
        chk("stall_err_sticky", 32'(stall_err), 32'd1);
        chk("stall_words", 32'(words_sent), 32'd14);

        // Scenario 6: reset mid-burst, then a fresh burst.
        drive(1, 8'd4, 0, 8'h00, 0);
        drive(0, 8'd0, 1, 8'hC1, 0);
        drive(0, 8'd0, 1, 8'hC2, 0);
        drive(0, 8'd0, 0, 8'h00, 0);
        #2 w_rst = 1'b1;
        #1;
        chk("mid_rst_fifo_w_en", 32'(fifo_w_en), 32'd0);
        chk("mid_rst_fifo_data", 32'(fifo_data_in), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_words", 32'(words_sent), 32'd0);
        chk("mid_rst_stall_err", 32'(stall_err), 32'd0);
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        drive(1, 8'd2, 0, 8'h00, 0);
        drive(0, 8'd0, 1, 8'hD1, 0);
        drive(0, 8'd0, 1, 8'hD2, 0);
        drive(0, 8'd0, 0, 8'h00, 0);
        wait_done("post_rst_done");
        chk("post_rst_words", 32'(words_sent), 32'd3);
        chk("post_rst_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge w_clk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
